// File: rtl/uart_pkg.sv
// Shared UART register map and scheduler FSM encoding.
package uart_pkg;
  localparam logic [1:0] ADDR_BAUD    = 2'b00;
  localparam logic [1:0] ADDR_TX_EN   = 2'b01;
  localparam logic [1:0] ADDR_TX_DATA = 2'b10;
  localparam logic [1:0] ADDR_RX_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_CFG,
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_STOP
  } state_t;
endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin pick: first requester found searching upward from last+1, wrapping.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       any
);
  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest one after 'last' wins.
  always_comb begin
    grant = last;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (req[idx]) grant = idx;
    end
  end

  assign any = |req;
endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates byte requesters onto a register-mapped UART transmitter.
// Optional UART_TX_SCHED_LOCK_EN: keep a requester granted until it flags req_last.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FRAME_BITS = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                baud_div,
  input  logic                       cfg_update,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0][7:0]    req_data,
`ifdef UART_TX_SCHED_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_last,
`endif
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [1:0]                 address,
  output logic                       write_enable,
  output logic [31:0]                write_data,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int IW = $clog2(NUM_REQ);

  state_t        state, state_n;
  logic          cfg_pend;
  logic [31:0]   baud_q, baud_eff;
  logic [7:0]    byte_q;
  logic [IW-1:0] last_grant, grant_q, arb_grant, take_id;
  logic          arb_any, take, lock_hit;
  logic [35:0]   cnt, wait_len;
  logic          we;
  logic [1:0]    addr_q, addr_c;
  logic [31:0]   wdata_q, wdata_c;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .last  (last_grant),
    .grant (arb_grant),
    .any   (arb_any)
  );

  // 36-bit product so the largest divisor times the frame length cannot wrap.
  assign baud_eff = (baud_q == 32'd0) ? 32'd1 : baud_q;
  assign wait_len = 36'(FRAME_BITS) * {4'd0, baud_eff};

`ifdef UART_TX_SCHED_LOCK_EN
  logic lock_q;
  assign lock_hit = lock_q & req_valid[grant_q];
`else
  assign lock_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    take    = 1'b0;
    take_id = arb_grant;
    we      = 1'b0;
    addr_c  = addr_q;
    wdata_c = wdata_q;
    case (state)
      S_CFG: begin
        we      = 1'b1;
        addr_c  = ADDR_BAUD;
        wdata_c = baud_div;
        state_n = S_IDLE;
      end
      S_IDLE: begin
        if (cfg_pend || cfg_update) begin
          state_n = S_CFG;
        end else if (lock_hit) begin
          take    = 1'b1;
          take_id = grant_q;
          state_n = S_LOAD;
        end else if (arb_any) begin
          take    = 1'b1;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        we      = 1'b1;
        addr_c  = ADDR_TX_DATA;
        wdata_c = {24'd0, byte_q};
        state_n = S_START;
      end
      S_START: begin
        we      = 1'b1;
        addr_c  = ADDR_TX_EN;
        wdata_c = 32'd1;
        state_n = S_WAIT;
      end
      S_WAIT: if (cnt == 36'd1) state_n = S_STOP;
      S_STOP: begin
        we      = 1'b1;
        addr_c  = ADDR_TX_EN;
        wdata_c = 32'd0;
        state_n = S_IDLE;
      end
      default: state_n = S_CFG;
    endcase
  end

  // Reset forces the visible outputs immediately, before the state register catches up.
  assign req_ready    = (take && !rst) ? (NUM_REQ'(1) << take_id) : '0;
  assign write_enable = we & ~rst;
  assign address      = rst ? 2'b00 : addr_c;
  assign write_data   = rst ? 32'd0 : wdata_c;
  assign busy         = rst | (state != S_IDLE);
  assign grant_id     = rst ? '0 : grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CFG;
      cfg_pend   <= 1'b0;
      baud_q     <= 32'd0;
      byte_q     <= 8'd0;
      last_grant <= IW'(NUM_REQ - 1);
      grant_q    <= '0;
      cnt        <= 36'd0;
      addr_q     <= 2'b00;
      wdata_q    <= 32'd0;
`ifdef UART_TX_SCHED_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cfg_pend <= (state == S_CFG) ? cfg_update : (cfg_pend | cfg_update);
      if (state == S_CFG) baud_q <= baud_div;
      if (we) begin
        addr_q  <= addr_c;
        wdata_q <= wdata_c;
      end
      if (take) begin
        byte_q     <= req_data[take_id];
        grant_q    <= take_id;
        last_grant <= take_id;
`ifdef UART_TX_SCHED_LOCK_EN
        lock_q     <= ~req_last[take_id];
`endif
      end
      if (state == S_START)     cnt <= wait_len;
      else if (state == S_WAIT) cnt <= cnt - 36'd1;
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: stimulus pushes expected grants/register writes, a negedge monitor pops and compares.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int NR = 4;
  localparam int FB = 10;
`ifdef UART_TX_SCHED_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef struct { logic [1:0] a; logic [31:0] d; int gap; } wr_t;
  typedef struct { int id; int gap; } gn_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       baud_div;
  logic              cfg_update;
  logic [NR-1:0]     req_valid, req_ready, req_last, extra;
  logic [NR-1:0][7:0] req_data;
  logic [1:0]        address;
  logic              write_enable;
  logic [31:0]       write_data;
  logic              busy;
  logic [1:0]        grant_id;

  wr_t        exp_wr[$];
  gn_t        exp_gn[$];
  logic [7:0] drv_q[NR][$];
  int tests = 0, fails = 0;
  int cyc = 0, last_wr = 0, last_gn = 0;
  int gexp = 0, gcount = 0, mlast = NR - 1;
  bit gid_pend = 1'b0;
  int gid_exp = 0;

  uart_tx_scheduler #(.NUM_REQ(NR), .FRAME_BITS(FB)) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_div     (baud_div),
    .cfg_update   (cfg_update),
    .req_valid    (req_valid),
    .req_data     (req_data),
`ifdef UART_TX_SCHED_LOCK_EN
    .req_last     (req_last),
`endif
    .req_ready    (req_ready),
    .address      (address),
    .write_enable (write_enable),
    .write_data   (write_data),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wlen(input int b);
    return FB * ((b == 0) ? 1 : b);
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] m, input int last);
    for (int k = 1; k <= NR; k++) if (m[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  function automatic bit drv_busy();
    for (int i = 0; i < NR; i++) if (drv_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_frame(input int id, input logic [7:0] b, input int n, input int ggap);
    exp_gn.push_back('{id, ggap});
    exp_wr.push_back('{ADDR_TX_DATA, {24'd0, b}, 0});
    exp_wr.push_back('{ADDR_TX_EN, 32'd1, 1});
    exp_wr.push_back('{ADDR_TX_EN, 32'd0, n + 1});
    gexp++;
    mlast = id;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((exp_wr.size() != 0 || exp_gn.size() != 0 || busy || drv_busy()) && n < 4000);
    check({tag, "_done"}, longint'(n < 4000), 1);
  endtask

  task automatic rst_checks(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_we"}, write_enable, 0);
    check({tag, "_addr"}, address, 0);
    check({tag, "_wdata"}, write_data, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_gid"}, grant_id, 0);
  endtask

  task automatic cfg(input int b);
    baud_div = 32'(b);
    cfg_update = 1'b1;
    exp_wr.push_back('{ADDR_BAUD, 32'(b), 0});
    @(posedge clk); #1 cfg_update = 1'b0;
    wait_idle("cfg");
  endtask

  // Transaction-level model: each requester holds its bytes continuously, so grants
  // follow round-robin over non-empty queues, back to back every 4+N cycles.
  task automatic run_batch(input int c[NR], input int b);
    int left[NR];
    logic [7:0] mb[NR][4];
    logic [NR-1:0] m;
    bit lk, first;
    int g;
    cfg(b);
    for (int i = 0; i < NR; i++) begin
      left[i] = c[i];
      for (int k = 0; k < c[i]; k++) mb[i][k] = 8'($urandom);
    end
    lk = 1'b0;
    first = 1'b1;
    forever begin
      for (int i = 0; i < NR; i++) m[i] = (left[i] > 0);
      if (m == '0) break;
      g = (LOCK && lk && m[mlast]) ? mlast : rr_pick(m, mlast);
      push_frame(g, mb[g][c[g] - left[g]], wlen(b), first ? 0 : 4 + wlen(b));
      left[g]--;
      lk = (left[g] > 0);
      first = 1'b0;
    end
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < c[i]; k++) drv_q[i].push_back(mb[i][k]);
    wait_idle("batch");
  endtask

  // Requester driver: present queue heads, retire a byte after its handshake.
  initial begin
    logic [NR-1:0] hs;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      hs = req_ready & req_valid;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (hs[i] && drv_q[i].size() != 0) void'(drv_q[i].pop_front());
        req_valid[i] = (drv_q[i].size() != 0) || extra[i];
        req_data[i]  = (drv_q[i].size() != 0) ? drv_q[i][0] : 8'($urandom);
        req_last[i]  = (drv_q[i].size() <= 1);
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      last_wr  = cyc;
      gid_pend = 1'b0;
    end else begin
      if (gid_pend) begin
        check("grant_id", grant_id, gid_exp);
        gid_pend = 1'b0;
      end
      if (write_enable) begin
        if (exp_wr.size() == 0) check("wr_unexpected", write_enable, 0);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr", address, e.a);
          check("wr_data", write_data, e.d);
          if (e.gap != 0) check("wr_gap", cyc - last_wr, e.gap);
        end
        last_wr = cyc;
      end
      if (req_ready != '0) begin
        gcount++;
        if (exp_gn.size() == 0) check("gnt_unexpected", req_ready, 0);
        else begin
          gn_t g;
          g = exp_gn.pop_front();
          check("gnt_onehot", req_ready, NR'(1) << g.id);
          if (g.gap != 0) check("gnt_gap", cyc - last_gn, g.gap);
          gid_exp  = g.id;
          gid_pend = 1'b1;
        end
        last_gn = cyc;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c[NR];
    logic [7:0] b, b2;
    rst = 1'b1; baud_div = 32'd5; cfg_update = 1'b0; extra = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_checks("por");
    exp_wr.push_back('{ADDR_BAUD, 32'd5, 1});
    @(posedge clk); #1 rst = 1'b0;
    wait_idle("por_cfg");
    check("idle_busy", busy, 0);

    c = '{2, 1, 1, 1}; run_batch(c, 1);
    c = '{0, 3, 0, 1}; run_batch(c, 0);
    repeat (4) begin
      for (int i = 0; i < NR; i++) c[i] = $urandom_range(0, 3);
      run_batch(c, $urandom_range(0, 3));
    end

    // cfg_update during a frame: finish the frame, reprogram, then short frame
    cfg(5);
    b = 8'($urandom);
    drv_q[0].push_back(b);
    push_frame(0, b, wlen(5), 0);
    repeat (25) @(posedge clk); #1;
    baud_div = 32'd0; cfg_update = 1'b1;
    exp_wr.push_back('{ADDR_BAUD, 32'd0, 2});
    b2 = 8'($urandom);
    drv_q[1].push_back(b2);
    push_frame(1, b2, wlen(0), 4 + wlen(5) + 2);
    @(posedge clk); #1 cfg_update = 1'b0;
    wait_idle("cfg_mid_wait");

    // reset in the middle of the wait
    cfg(3);
    b = 8'($urandom);
    drv_q[2].push_back(b);
    push_frame(2, b, wlen(3), 0);
    repeat (14) @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    rst_checks("rst_mid_wait");
    check("aborted_writes", exp_wr.size(), 1);
    @(posedge clk); @(negedge clk);
    check("we_after_rst", write_enable, 0);
    exp_wr.delete();
    exp_gn.delete();
    mlast = NR - 1;
    exp_wr.push_back('{ADDR_BAUD, 32'd3, 1});
    @(posedge clk); #1 rst = 1'b0;
    wait_idle("rst_cfg");

    // requester 1 pulses valid only while the block is busy: never served
    b = 8'($urandom);
    drv_q[0].push_back(b);
    push_frame(0, b, wlen(3), 0);
    repeat (8) @(posedge clk); #1 extra = 4'b0010;
    repeat (10) @(posedge clk); #1 extra = '0;
    wait_idle("drop");
    check("grant_count", gcount, gexp);
    check("queues_empty", exp_wr.size() + exp_gn.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
